// File: rtl/fifo_pkg.sv
// Shared definitions for the asynchronous FIFO: default geometry and the
// Gray/binary pointer conversions used by both clock domains.
package fifo_pkg;

  localparam int DEF_ADDR_W = 3;
  localparam int DEF_DATA_W = 8;

  // Widest pointer the conversion helpers handle; callers zero-extend
  // narrower pointers and truncate the result back to their own width.
  localparam int PTR_MAX_W = 16;

  typedef logic [PTR_MAX_W-1:0] ptr_word_t;

  function automatic ptr_word_t bin2gray(input ptr_word_t b);
    return b ^ (b >> 1);
  endfunction

  // Zero upper bits stay zero through the prefix XOR, so zero-extended
  // narrow pointers convert correctly.
  function automatic ptr_word_t gray2bin(input ptr_word_t g);
    ptr_word_t b;
    b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
    for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_ptr_sync.sv
// Two-flop synchronizer for a Gray-coded pointer crossing into the local
// clock domain. Shared by the read and write sides of the FIFO.
module fifo_ptr_sync #(
  parameter int WIDTH = 4
) (
  input  logic             rclk,
  input  logic             rrst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] sync_p0;

  // First flop may go metastable; second flop gives it a cycle to settle.
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      sync_p0 <= '0;
      q       <= '0;
    end else begin
      sync_p0 <= d;
      q       <= sync_p0;
    end
  end

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of an asynchronous FIFO: synchronizes the write
// pointer, generates the memory read address and Gray read pointer, keeps
// the registered empty flag and fill level, and presents popped words in a
// single output register with a valid/ready handshake.
module fifo_rd_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              rclk,
  input  logic              rrst,
  input  logic [ADDR_W:0]   wptr,
  input  logic [DATA_W-1:0] rdata_mem,
  output logic [ADDR_W-1:0] raddr,
  output logic [ADDR_W:0]   rptr,
  output logic              rempty,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [ADDR_W:0]   rlevel
);

  localparam int PTR_W = ADDR_W + 1;

  logic [PTR_W-1:0] rq2_wptr;
  logic [PTR_W-1:0] rptr_bin;
  logic [PTR_W-1:0] rbin_next;
  logic [PTR_W-1:0] rgray_next;
  logic [PTR_W-1:0] wbin_sync;
  logic             pop;

  // The synchronizer is the only consumer of the foreign-domain pointer.
  fifo_ptr_sync #(
    .WIDTH (PTR_W)
  ) u_wptr_sync (
    .rclk (rclk),
    .rrst (rrst),
    .d    (wptr),
    .q    (rq2_wptr)
  );

  // A word leaves memory whenever one exists and the output register is
  // free or being emptied in the same cycle.
  assign pop        = !rempty && (!rd_valid || rd_ready);
  assign rbin_next  = rptr_bin + PTR_W'(pop);
  assign rgray_next = PTR_W'(bin2gray(PTR_MAX_W'(rbin_next)));
  assign wbin_sync  = PTR_W'(gray2bin(PTR_MAX_W'(rq2_wptr)));
  assign raddr      = rptr_bin[ADDR_W-1:0];

  // Pointer, empty flag and level all look at the post-pop pointer so the
  // flag is already correct in the cycle after the last word is taken.
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      rptr_bin <= '0;
      rptr     <= '0;
      rempty   <= 1'b1;
      rlevel   <= '0;
    end else begin
      rptr_bin <= rbin_next;
      rptr     <= rgray_next;
      rempty   <= (rgray_next == rq2_wptr);
      rlevel   <= wbin_sync - rbin_next;
    end
  end

  // Output register: load on pop (including when the held word is accepted
  // in the same cycle), drop valid when accepted with nothing to replace it,
  // otherwise hold.
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else if (pop) begin
      rd_data  <= rdata_mem;
      rd_valid <= 1'b1;
    end else if (rd_valid && rd_ready) begin
      rd_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Bench for the FIFO read controller: models the memory and write side,
// and scores delivered words against a queue filled at write time.
module tb_fifo_rd_ctrl;

  logic       rclk;
  logic       rrst;
  logic [3:0] wptr;
  logic [7:0] rdata_mem;
  logic [2:0] raddr;
  logic [3:0] rptr;
  logic       rempty;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       rd_ready;
  logic [3:0] rlevel;

  logic [7:0] mem [0:7];
  logic [3:0] wcnt;
  logic [7:0] q[$];
  int         n_assert;
  int         n_fail;

  fifo_rd_ctrl #(.ADDR_W(3), .DATA_W(8)) dut (
    .rclk      (rclk),
    .rrst      (rrst),
    .wptr      (wptr),
    .rdata_mem (rdata_mem),
    .raddr     (raddr),
    .rptr      (rptr),
    .rempty    (rempty),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .rlevel    (rlevel)
  );

  assign rdata_mem = mem[raddr];

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  function automatic logic [3:0] to_gray(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic push_word(input logic [7:0] d);
    mem[wcnt[2:0]] = d;
    wcnt = wcnt + 4'd1;
    wptr = to_gray(wcnt);
    q.push_back(d);
  endtask

  task automatic do_reset();
    rrst = 1'b1;
    wptr = 4'd0;
    wcnt = 4'd0;
    rd_ready = 1'b0;
    q.delete();
    repeat (2) @(negedge rclk);
    rrst = 1'b0;
    @(negedge rclk);
  endtask

  task automatic test_reset();
    @(negedge rclk);
    n_assert++; if (rempty !== 1'b1) begin n_fail++; $display("FAIL reset_rempty: got %b, required 1", rempty); end
    n_assert++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid: got %b, required 0", rd_valid); end
    n_assert++; if (rptr !== 4'd0) begin n_fail++; $display("FAIL reset_rptr: got %h, required 0", rptr); end
    n_assert++; if (rlevel !== 4'd0) begin n_fail++; $display("FAIL reset_rlevel: got %0d, required 0", rlevel); end
    n_assert++; if (rd_data !== 8'd0) begin n_fail++; $display("FAIL reset_rd_data: got %h, required 00", rd_data); end
    rrst = 1'b0;
    @(negedge rclk);
    rd_ready = 1'b0;
    push_word(8'h3C);
    repeat (4) @(negedge rclk);
    n_assert++; if (rd_valid !== 1'b1 || rd_data !== 8'h3C) begin n_fail++; $display("FAIL reset_prefill: got valid=%b data=%h, required valid=1 data=3c", rd_valid, rd_data); end
    // Mid-cycle asynchronous reset while a word sits in the output register.
    @(posedge rclk);
    #2;
    rrst = 1'b1;
    wptr = 4'd0;
    wcnt = 4'd0;
    q.delete();
    #1;
    n_assert++; if (rempty !== 1'b1) begin n_fail++; $display("FAIL async_rempty: got %b, required 1", rempty); end
    n_assert++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL async_rd_valid: got %b, required 0", rd_valid); end
    n_assert++; if (rptr !== 4'd0) begin n_fail++; $display("FAIL async_rptr: got %h, required 0", rptr); end
    n_assert++; if (rlevel !== 4'd0) begin n_fail++; $display("FAIL async_rlevel: got %0d, required 0", rlevel); end
    @(negedge rclk);
    @(negedge rclk);
    rrst = 1'b0;
    @(negedge rclk);
    n_assert++; if (rd_valid !== 1'b0 || rptr !== 4'd0 || rempty !== 1'b1) begin n_fail++; $display("FAIL reset_release: got valid=%b rptr=%h empty=%b, required 0/0/1", rd_valid, rptr, rempty); end
  endtask

  task automatic test_single();
    logic [7:0] exp_d;
    rd_ready = 1'b1;
    push_word(8'hA5);
    repeat (2) @(negedge rclk);
    n_assert++; if (rempty !== 1'b1) begin n_fail++; $display("FAIL single_edge2_rempty: got %b, required 1", rempty); end
    @(negedge rclk);
    n_assert++; if (rempty !== 1'b0 || rd_valid !== 1'b0) begin n_fail++; $display("FAIL single_edge3: got empty=%b valid=%b, required 0/0", rempty, rd_valid); end
    n_assert++; if (rlevel !== 4'd1) begin n_fail++; $display("FAIL single_edge3_rlevel: got %0d, required 1", rlevel); end
    @(negedge rclk);
    n_assert++; if (rd_valid !== 1'b1) begin n_fail++; $display("FAIL single_edge4_valid: got %b, required 1", rd_valid); end
    n_assert++; if (rptr !== 4'b0001 || rempty !== 1'b1 || rlevel !== 4'd0) begin n_fail++; $display("FAIL single_edge4_ptr: got rptr=%b empty=%b level=%0d, required 0001/1/0", rptr, rempty, rlevel); end
    if (rd_valid && rd_ready) begin
      exp_d = q.pop_front();
      n_assert++; if (rd_data !== exp_d) begin n_fail++; $display("FAIL single_data: got %h, required %h", rd_data, exp_d); end
    end
    @(negedge rclk);
    n_assert++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL single_consumed: got valid=%b, required 0", rd_valid); end
  endtask

  task automatic test_full();
    logic [7:0] exp_d;
    logic [7:0] held;
    do_reset();
    for (int i = 0; i < 8; i++) push_word(8'h80 + 8'(i));
    held = q[0];
    repeat (3) @(negedge rclk);
    n_assert++; if (rlevel !== 4'd8) begin n_fail++; $display("FAIL full_rlevel: got %0d, required 8", rlevel); end
    n_assert++; if (rempty !== 1'b0 || rd_valid !== 1'b0) begin n_fail++; $display("FAIL full_edge3: got empty=%b valid=%b, required 0/0", rempty, rd_valid); end
    @(negedge rclk);
    n_assert++; if (rd_valid !== 1'b1 || rd_data !== held) begin n_fail++; $display("FAIL full_first: got valid=%b data=%h, required 1/%h", rd_valid, rd_data, held); end
    n_assert++; if (rptr !== 4'b0001 || rlevel !== 4'd7) begin n_fail++; $display("FAIL full_one_pop: got rptr=%b level=%0d, required 0001/7", rptr, rlevel); end
    for (int c = 0; c < 5; c++) begin
      @(negedge rclk);
      n_assert++; if (rd_valid !== 1'b1 || rd_data !== held || rptr !== 4'b0001) begin n_fail++; $display("FAIL full_stall: got valid=%b data=%h rptr=%b, required 1/%h/0001", rd_valid, rd_data, rptr, held); end
    end
    rd_ready = 1'b1;
    for (int c = 0; c < 40 && q.size() != 0; c++) begin
      if (rd_valid && rd_ready) begin
        exp_d = q.pop_front();
        n_assert++; if (rd_data !== exp_d) begin n_fail++; $display("FAIL full_drain_data: got %h, required %h", rd_data, exp_d); end
      end
      @(negedge rclk);
    end
    n_assert++; if (q.size() != 0) begin n_fail++; $display("FAIL full_drain_done: got %0d words left, required 0", q.size()); end
  endtask

  task automatic test_stream();
    logic [7:0] exp_d;
    int n_valid;
    bit ended;
    bit gap;
    do_reset();
    n_valid = 0; ended = 0; gap = 0;
    for (int i = 0; i < 8; i++) push_word(8'h10 + 8'(i));
    rd_ready = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge rclk);
      if (rd_valid) begin
        if (ended) gap = 1;
        n_valid++;
      end else if (n_valid > 0) begin
        ended = 1;
      end
      if (rd_valid && rd_ready) begin
        n_assert++;
        if (q.size() == 0) begin n_fail++; $display("FAIL stream_extra: got %h, required no word", rd_data); end
        else begin
          exp_d = q.pop_front();
          if (rd_data !== exp_d) begin n_fail++; $display("FAIL stream_data: got %h, required %h", rd_data, exp_d); end
        end
      end
    end
    n_assert++; if (n_valid != 8 || gap) begin n_fail++; $display("FAIL stream_burst: got %0d valid cycles gap=%0d, required 8 contiguous", n_valid, gap); end
    n_assert++; if (rempty !== 1'b1 || rlevel !== 4'd0) begin n_fail++; $display("FAIL stream_end: got empty=%b level=%0d, required 1/0", rempty, rlevel); end
    n_assert++; if (q.size() != 0) begin n_fail++; $display("FAIL stream_left: got %0d words left, required 0", q.size()); end
  endtask

  task automatic test_backpressure();
    logic [7:0] exp_d;
    int n_got;
    n_got = 0;
    for (int i = 0; i < 4; i++) push_word(8'hC0 + 8'(i));
    for (int c = 0; c < 40; c++) begin
      @(negedge rclk);
      rd_ready = ~rd_ready;
      if (rd_valid && rd_ready) begin
        n_assert++;
        if (q.size() == 0) begin n_fail++; $display("FAIL bp_duplicate: got %h, required no word", rd_data); end
        else begin
          exp_d = q.pop_front();
          n_got++;
          if (rd_data !== exp_d) begin n_fail++; $display("FAIL bp_data: got %h, required %h", rd_data, exp_d); end
        end
      end
    end
    n_assert++; if (n_got != 4) begin n_fail++; $display("FAIL bp_count: got %0d words, required 4", n_got); end
    n_assert++; if (rd_valid !== 1'b0 || rempty !== 1'b1) begin n_fail++; $display("FAIL bp_idle: got valid=%b empty=%b, required 0/1", rd_valid, rempty); end
  endtask

  task automatic test_wrap();
    logic [7:0] exp_d;
    logic [3:0] prev_rptr;
    logic [2:0] prev_raddr;
    int written;
    int n_got;
    bit saw_wrap;
    bit saw_awrap;
    written = 0; n_got = 0; saw_wrap = 0; saw_awrap = 0;
    prev_rptr = rptr;
    prev_raddr = raddr;
    for (int c = 0; c < 400 && !(written == 20 && q.size() == 0); c++) begin
      @(negedge rclk);
      n_assert++; if ($countones(rptr ^ prev_rptr) > 1) begin n_fail++; $display("FAIL wrap_gray_step: got %b -> %b, required one bit change", prev_rptr, rptr); end
      if (prev_rptr == 4'b1000 && rptr == 4'b0000) saw_wrap = 1;
      if (prev_raddr == 3'd7 && raddr == 3'd0) saw_awrap = 1;
      prev_rptr = rptr;
      prev_raddr = raddr;
      rd_ready = ($urandom_range(0, 3) != 0);
      if (rd_valid && rd_ready) begin
        n_assert++;
        if (q.size() == 0) begin n_fail++; $display("FAIL wrap_extra: got %h, required no word", rd_data); end
        else begin
          exp_d = q.pop_front();
          n_got++;
          if (rd_data !== exp_d) begin n_fail++; $display("FAIL wrap_data: got %h, required %h", rd_data, exp_d); end
        end
      end
      if (written < 20 && q.size() < 8 && $urandom_range(0, 3) != 0) begin
        push_word(8'($urandom));
        written++;
      end
    end
    n_assert++; if (n_got != 20 || q.size() != 0) begin n_fail++; $display("FAIL wrap_count: got %0d words (%0d pending), required 20", n_got, q.size()); end
    n_assert++; if (!saw_wrap) begin n_fail++; $display("FAIL wrap_rptr: got no 1000->0000 transition, required one"); end
    n_assert++; if (!saw_awrap) begin n_fail++; $display("FAIL wrap_raddr: got no 7->0 transition, required one"); end
  endtask

  initial begin
    n_assert = 0;
    n_fail = 0;
    rrst = 1'b1;
    wptr = 4'd0;
    wcnt = 4'd0;
    rd_ready = 1'b0;
    for (int i = 0; i < 8; i++) mem[i] = 8'd0;
    test_reset();
    test_single();
    test_full();
    test_stream();
    test_backpressure();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
